// File: rtl/chan_scan_seq_if.sv
// Channel-scan sequencer bus bundle.
// Groups the control, configuration, sample handshake and status signals of
// chan_scan_seq so the sequencer and its driver share one port definition.
//   master : drives start/stop/cont/mask/dwell/sample_ack/irq_clr, observes status
//   slave  : the sequencer side (chan_scan_seq)
interface chan_scan_seq_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               cont;
    logic [7:0]         mask;
    logic [DWELL_W-1:0] dwell;
    logic [2:0]         sel;
    logic               sel_vld;
    logic               sample_req;
    logic               sample_ack;
    logic               busy;
    logic               sweep_done;
    logic               irq;
    logic               irq_clr;

    modport master (
        output start, stop, cont, mask, dwell, sample_ack, irq_clr,
        input  sel, sel_vld, sample_req, busy, sweep_done, irq
    );

    modport slave (
        input  start, stop, cont, mask, dwell, sample_ack, irq_clr,
        output sel, sel_vld, sample_req, busy, sweep_done, irq
    );
endinterface

// File: rtl/chan_scan_seq.sv
// Channel-scan sequencer for the 3-to-8 one-hot decoder stage.
// Walks the enabled channels of a latched mask in ascending order, holds each
// channel for (dwell+1) cycles, then handshakes a sample request before moving
// on. Single-sweep or continuous (wrap) operation.
//
// Ports:
//   clk    : clock, all logic on rising edge
//   rst_n  : synchronous active-low reset
//   bus_if : chan_scan_seq_if.slave (start/stop/cont/mask/dwell in,
//            sel/sel_vld/sample_req out, sample_ack in, busy/sweep_done/irq out,
//            irq_clr in)
//
// Optional feature macro: SCAN_IRQ_EN
//   defined   : sticky irq set by every sweep_done, cleared by irq_clr (set wins)
//   undefined : irq tied low, irq_clr unused
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start with a non-empty mask; sel holds last value
// DWELL  | sel live, counting down the dwell time for the current channel
// REQ    | sample_req high, waiting for sample_ack to advance/wrap/stop
module chan_scan_seq #(
    parameter int DWELL_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    chan_scan_seq_if.slave bus_if
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_REQ   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [7:0]         mask_q, mask_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               stop_pend_q, stop_pend_d;
    logic               done_q, done_d;
    logic               vld_q, req_q;
    logic [7:0]         above;
    logic               stop_eff;

    function automatic logic [2:0] lowest_bit(input logic [7:0] v);
        lowest_bit = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_bit = 3'(i);
        end
    endfunction

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        stop_pend_d = stop_pend_q;
        done_d      = 1'b0;
        // Enabled channels strictly above the current one.
        above       = mask_q & (8'hFE << sel_q);
        // A stop arriving together with the ack still ends the scan on that ack.
        stop_eff    = stop_pend_q | bus_if.stop;

        case (state_q)
            S_IDLE: begin
                if (bus_if.start && !bus_if.stop && (bus_if.mask != 8'd0)) begin
                    mask_d  = bus_if.mask;
                    sel_d   = lowest_bit(bus_if.mask);
                    cnt_d   = bus_if.dwell;
                    state_d = S_DWELL;
                end
            end
            S_DWELL: begin
                stop_pend_d = stop_eff;
                if (cnt_q == '0) state_d = S_REQ;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_REQ: begin
                stop_pend_d = stop_eff;
                if (bus_if.sample_ack) begin
                    if (stop_eff) begin
                        state_d     = S_IDLE;
                        stop_pend_d = 1'b0;
                        done_d      = (above == 8'd0);
                    end else if (above != 8'd0) begin
                        sel_d   = lowest_bit(above);
                        cnt_d   = bus_if.dwell;
                        state_d = S_DWELL;
                    end else begin
                        done_d = 1'b1;
                        if (bus_if.cont && (bus_if.mask != 8'd0)) begin
                            mask_d  = bus_if.mask;
                            sel_d   = lowest_bit(bus_if.mask);
                            cnt_d   = bus_if.dwell;
                            state_d = S_DWELL;
                        end else begin
                            state_d     = S_IDLE;
                            stop_pend_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sel_q       <= 3'd0;
            mask_q      <= 8'd0;
            cnt_q       <= '0;
            stop_pend_q <= 1'b0;
            done_q      <= 1'b0;
            vld_q       <= 1'b0;
            req_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            stop_pend_q <= stop_pend_d;
            done_q      <= done_d;
            // Status flops decode the next state so they move on the same edge.
            vld_q       <= (state_d != S_IDLE);
            req_q       <= (state_d == S_REQ);
        end
    end

    assign bus_if.sel        = sel_q;
    assign bus_if.sel_vld    = vld_q;
    assign bus_if.busy       = vld_q;
    assign bus_if.sample_req = req_q;
    assign bus_if.sweep_done = done_q;

`ifdef SCAN_IRQ_EN
    logic irq_q;

    // Set from the sweep_done pulse so a clear in that same cycle loses.
    always_ff @(posedge clk) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= done_q | (irq_q & ~bus_if.irq_clr);
    end

    assign bus_if.irq = irq_q;
`else
    logic unused_irq_clr;
    assign unused_irq_clr = bus_if.irq_clr;
    assign bus_if.irq     = 1'b0;
`endif
endmodule

// File: tb/tb_chan_scan_seq.sv
module tb_chan_scan_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    chan_scan_seq_if #(.DWELL_W(8)) intf ();
    chan_scan_seq #(.DWELL_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus_if(intf));

`ifdef SCAN_IRQ_EN
    localparam int IRQ_EXP = 1;
`else
    localparam int IRQ_EXP = 0;
`endif

    int checks = 0;
    int failures = 0;

    // Observations from the last sweep.
    int got_sel[$];
    int got_dw[$];
    int got_rq[$];
    int used_dly[$];
    int ndone, bcyc, vld_err, iters;

    typedef struct {
        logic [7:0] mask;
        logic [7:0] dwell;
        int         exp_n;
        int         exp_last;
        int         exp_cyc;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    // Runs one scan from IDLE until busy drops (bounded), recording each
    // acknowledged channel with its dwell and request lengths.
    task automatic sweep(input logic [7:0] m, input logic [7:0] d, input logic c,
                         input logic tie_ack, input int maxdly, input logic [7:0] m_mid,
                         input int stop_ch, input int force_ch, input int force_dly);
        int dcnt, rcnt, dly;
        logic stop_fired;
        got_sel.delete(); got_dw.delete(); got_rq.delete(); used_dly.delete();
        ndone = 0; bcyc = 0; vld_err = 0;
        dcnt = 0; rcnt = 0; dly = 0; stop_fired = 1'b0;
        intf.mask = m; intf.dwell = d; intf.cont = c; intf.start = 1'b1;
        intf.sample_ack = tie_ack;
        @(negedge clk);
        intf.start = 1'b0;
        intf.mask = m_mid;
        for (iters = 0; iters < 3000; iters++) begin
            if (intf.sweep_done) ndone++;
            if (!intf.busy) break;
            if (!intf.sel_vld) vld_err++;
            bcyc++;
            if (!stop_fired && stop_ch >= 0 && intf.sel_vld && !intf.sample_req
                && int'(intf.sel) == stop_ch) begin
                intf.stop = 1'b1;
                stop_fired = 1'b1;
            end else begin
                intf.stop = 1'b0;
            end
            if (intf.sample_req) begin
                rcnt++;
                if (rcnt == 1)
                    dly = (int'(intf.sel) == force_ch) ? force_dly :
                          (tie_ack ? 0 : int'($urandom_range(0, maxdly)));
                if (rcnt > dly) begin
                    intf.sample_ack = 1'b1;
                    got_sel.push_back(int'(intf.sel));
                    got_dw.push_back(dcnt);
                    got_rq.push_back(rcnt);
                    used_dly.push_back(dly);
                    dcnt = 0;
                    rcnt = 0;
                end else begin
                    intf.sample_ack = 1'b0;
                end
            end else begin
                dcnt++;
                intf.sample_ack = tie_ack ? 1'b1 : 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        chk("sweep_ends", int'(intf.busy), 0);
        intf.sample_ack = 1'b0;
        intf.stop = 1'b0;
        intf.cont = 1'b0;
        @(negedge clk);
        if (intf.sweep_done) ndone++;
    endtask

    // Reference: a single sweep visits the set bits of the mask in ascending
    // order, each for d+1 dwell cycles plus (ack delay + 1) request cycles.
    task automatic check_model(input logic [7:0] m, input logic [7:0] d);
        int exp_ch[$];
        int exp_cyc;
        exp_cyc = 0;
        for (int ch = 0; ch < 8; ch++) if (m[ch]) exp_ch.push_back(ch);
        chk("n_channels", got_sel.size(), exp_ch.size());
        for (int i = 0; i < exp_ch.size() && i < got_sel.size(); i++) begin
            chk("sel_order", got_sel[i], exp_ch[i]);
            chk("dwell_len", got_dw[i], int'(d) + 1);
            chk("req_len", got_rq[i], used_dly[i] + 1);
            exp_cyc += int'(d) + 1 + used_dly[i] + 1;
        end
        chk("busy_cycles", bcyc, exp_cyc);
        chk("sweep_done_cnt", ndone, 1);
        chk("sel_vld_while_busy", vld_err, 0);
    endtask

    initial begin
        intf.start = 1'b0; intf.stop = 1'b0; intf.cont = 1'b0;
        intf.mask = 8'd0; intf.dwell = 8'd0; intf.sample_ack = 1'b0; intf.irq_clr = 1'b0;

        vecs[0] = '{8'hFF, 8'd2, 8, 7, 32};
        vecs[1] = '{8'hA4, 8'd0, 3, 7, 6};
        vecs[2] = '{8'h01, 8'd5, 1, 0, 7};
        vecs[3] = '{8'h80, 8'd1, 1, 7, 3};
        vecs[4] = '{8'h18, 8'd3, 2, 4, 10};
        vecs[5] = '{8'h42, 8'd0, 2, 6, 4};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sel", int'(intf.sel), 0);
        chk("rst_sel_vld", int'(intf.sel_vld), 0);
        chk("rst_req", int'(intf.sample_req), 0);
        chk("rst_busy", int'(intf.busy), 0);
        chk("rst_done", int'(intf.sweep_done), 0);
        chk("rst_irq", int'(intf.irq), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors, ack tied high.
        for (int v = 0; v < 6; v++) begin
            sweep(vecs[v].mask, vecs[v].dwell, 1'b0, 1'b1, 0, vecs[v].mask, -1, -1, 0);
            chk("tbl_n", got_sel.size(), vecs[v].exp_n);
            chk("tbl_last", (got_sel.size() > 0) ? got_sel[$] : -1, vecs[v].exp_last);
            chk("tbl_cyc", bcyc, vecs[v].exp_cyc);
            check_model(vecs[v].mask, vecs[v].dwell);
        end

        // Ack held off 5 cycles at channel 3.
        sweep(8'h18, 8'd1, 1'b0, 1'b0, 0, 8'h18, -1, 3, 5);
        chk("ch3_req_len", (got_rq.size() > 0) ? got_rq[0] : -1, 6);
        chk("after_ch3", (got_sel.size() > 1) ? got_sel[1] : -1, 4);
        check_model(8'h18, 8'd1);

        // Continuous mode, mask relatched only at the wrap, then stop on ch1.
        sweep(8'h81, 8'd1, 1'b1, 1'b1, 0, 8'h02, 1, -1, 0);
        chk("cont_n", got_sel.size(), 3);
        chk("cont_0", (got_sel.size() > 0) ? got_sel[0] : -1, 0);
        chk("cont_1", (got_sel.size() > 1) ? got_sel[1] : -1, 7);
        chk("cont_2", (got_sel.size() > 2) ? got_sel[2] : -1, 1);
        chk("cont_done", ndone, 2);
        chk("cont_cyc", bcyc, 9);

        // Sticky irq: clear held through the sweep_done cycle loses to the set.
        intf.irq_clr = 1'b1;
        sweep(8'h01, 8'd0, 1'b0, 1'b1, 0, 8'h01, -1, -1, 0);
        chk("irq_set_wins", int'(intf.irq), IRQ_EXP);
        @(negedge clk);
        chk("irq_cleared", int'(intf.irq), 0);
        intf.irq_clr = 1'b0;

        // Start with an empty mask is ignored.
        intf.mask = 8'h00; intf.start = 1'b1;
        @(negedge clk);
        intf.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("empty_mask_busy", int'(intf.busy), 0);

        // Start while dwelling is ignored; then reset during REQ.
        intf.mask = 8'h10; intf.dwell = 8'd5; intf.start = 1'b1; intf.sample_ack = 1'b0;
        @(negedge clk);
        intf.start = 1'b0;
        chk("dwell_sel", int'(intf.sel), 4);
        intf.mask = 8'hFF; intf.start = 1'b1;
        @(negedge clk);
        intf.start = 1'b0;
        chk("restart_ignored_sel", int'(intf.sel), 4);
        chk("restart_ignored_req", int'(intf.sample_req), 0);
        begin
            int n;
            for (n = 0; n < 20 && !intf.sample_req; n++) @(negedge clk);
            chk("reach_req", int'(intf.sample_req), 1);
        end
        chk("req_sel", int'(intf.sel), 4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_sel", int'(intf.sel), 0);
        chk("mid_rst_vld", int'(intf.sel_vld), 0);
        chk("mid_rst_req", int'(intf.sample_req), 0);
        chk("mid_rst_busy", int'(intf.busy), 0);
        chk("mid_rst_done", int'(intf.sweep_done), 0);
        chk("mid_rst_irq", int'(intf.irq), 0);
        @(negedge clk);

        // Randomized sweeps with random ack delays and stray acks.
        for (int r = 0; r < 20; r++) begin
            logic [7:0] rm, rd;
            rm = 8'($urandom_range(1, 255));
            rd = 8'($urandom_range(0, 4));
            sweep(rm, rd, 1'b0, 1'b0, 3, rm, -1, -1, 0);
            check_model(rm, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
